// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel port among NREQ producers (with burst lock); pixel registered 1 cycle after transfer.
// Backpressure: requesters without a grant stall holding req/data; define PLOT_CLIP_EN to drop off-screen pixels after handshake.
module vga_plot_arbiter #(
  parameter int NREQ     = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int LOCK_MAX = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ*X_W-1:0] px,
  input  logic [NREQ*Y_W-1:0] py,
  input  logic [NREQ*C_W-1:0] pcol,
  output logic [NREQ-1:0]     gnt,
  output logic [2:0]          owner,
  output logic                locked,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [C_W-1:0]      colour,
  output logic                plot
);

  localparam int TW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  if (NREQ < 2 || NREQ > 8 || X_MAX >= (1 << X_W) || Y_MAX >= (1 << Y_W)) begin : g_param_check
    $error("vga_plot_arbiter: parameter out of range");
  end

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [2:0]      last, last_d;
  logic [2:0]      owner_q, owner_d;
  logic [TW-1:0]   timer, timer_d;
  logic [2:0]      win, cur;
  logic            found, grant_any, xfer, emit, sel_lock;
  logic [X_W-1:0]  sel_x;
  logic [Y_W-1:0]  sel_y;
  logic [C_W-1:0]  sel_c;

  // Smallest rotation distance from last wins; descending k lets the nearest match overwrite.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ((int'(last) + k) % NREQ) == i) begin
          win   = 3'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign cur       = (state_q == ST_LOCKED) ? owner_q : win;
  assign grant_any = (state_q == ST_LOCKED) | found;

  always_comb begin
    gnt      = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cur == 3'(i)) begin
        gnt[i]   = grant_any;
        sel_x    = px[i*X_W +: X_W];
        sel_y    = py[i*Y_W +: Y_W];
        sel_c    = pcol[i*C_W +: C_W];
        sel_lock = lock[i];
      end
    end
  end

  assign xfer = |(req & gnt);

`ifdef PLOT_CLIP_EN
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);
  assign emit = xfer && (sel_x <= X_LIM) && (sel_y <= Y_LIM);
`else
  assign emit = xfer;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last;
    owner_d = owner_q;
    timer_d = timer;
    case (state_q)
      ST_ARB: begin
        if (xfer) begin
          last_d = cur;
          if (sel_lock) begin
            state_d = ST_LOCKED;
            owner_d = cur;
            timer_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        timer_d = timer + 1'b1;
        if (!sel_lock) begin
          state_d = ST_ARB;
        end else if (LOCK_MAX > 0 && timer == TW'(LOCK_MAX - 1)) begin
          // Forced release: owner goes to the back of the rotation.
          state_d = ST_ARB;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_ARB;
      last    <= 3'(NREQ - 1);
      owner_q <= '0;
      timer   <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
    end else begin
      state_q <= state_d;
      last    <= last_d;
      owner_q <= owner_d;
      timer   <= timer_d;
      plot    <= emit;
      if (emit) begin
        x      <= sel_x;
        y      <= sel_y;
        colour <= sel_c;
      end
    end
  end

  assign owner  = owner_q;
  assign locked = (state_q == ST_LOCKED);

endmodule
